// File: rtl/spi_reader.sv
// SPI initiator that reads a block of bytes from an SPI target and streams them
// into a local memory through a byte write port.
module spi_reader #(
    parameter int CLK_DIV    = 25,
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  cs,
    output logic                  sck,
    input  logic                  cipo,
    output logic [7:0]            wr_data,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  wr_en
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            bit_cnt;
    logic [LEN_WIDTH-1:0]  bytes_left;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            shift_reg;
    logic                  active;
    logic                  half_end;
    logic                  sck_rise;
    logic                  sck_fall;

    assign active   = (state == LEAD) || (state == SHIFT) || (state == TRAIL);
    assign half_end = (div_cnt == DIV_LAST);
    assign sck_rise = (state == SHIFT) && half_end && !sck;
    assign sck_fall = (state == SHIFT) && half_end && sck;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cs         = active;
        busy       = active;
        done       = (state == DONE);
        unique case (state)
            IDLE:  if (start) state_next = (length == '0) ? DONE : LEAD;
            LEAD:  if (half_end) state_next = SHIFT;
            SHIFT: if (sck_fall && bytes_left == '0) state_next = TRAIL;
            TRAIL: if (half_end) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The byte counter drops on each byte's 8th rising edge, so the falling edge
    // that finds it at zero is the very last one of the transfer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt    <= '0;
            sck        <= 1'b0;
            bit_cnt    <= '0;
            bytes_left <= '0;
            addr       <= '0;
            shift_reg  <= '0;
            wr_data    <= '0;
            wr_address <= '0;
            wr_en      <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            if (active && !half_end) div_cnt <= div_cnt + 1'b1;
            else                     div_cnt <= '0;

            if (state == SHIFT && half_end) sck <= ~sck;

            if (state == IDLE && start) begin
                addr       <= start_address;
                bytes_left <= length;
                bit_cnt    <= '0;
            end

            if (sck_rise) begin
                shift_reg <= {shift_reg[6:0], cipo};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    wr_data    <= {shift_reg[6:0], cipo};
                    wr_address <= addr;
                    wr_en      <= 1'b1;
                    addr       <= addr + 1'b1;
                    bytes_left <= bytes_left - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reader.sv
// Directed bench for spi_reader: a behavioural SPI target feeds cipo and a
// monitor records cs/sck/done activity and every write-port strobe.
module tb_spi_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [13:0] start_address;
    logic [13:0] length;
    logic        busy;
    logic        done;
    logic        cs;
    logic        sck;
    logic        cipo;
    logic [7:0]  wr_data;
    logic [13:0] wr_address;
    logic        wr_en;

    spi_reader #(.CLK_DIV(25), .ADDR_WIDTH(14), .LEN_WIDTH(14)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .start_address (start_address),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .cs            (cs),
        .sck           (sck),
        .cipo          (cipo),
        .wr_data       (wr_data),
        .wr_address    (wr_address),
        .wr_en         (wr_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural target: first bit ready when cs rises, next bit after each sck fall.
    logic [7:0] tgt [0:7];
    int         tbit = 0;

    always @(posedge cs) begin
        tbit = 0;
        cipo = tgt[0][7];
    end

    always @(negedge sck) begin
        if (cs) begin
            tbit = tbit + 1;
            if (tbit < 64) cipo = tgt[tbit / 8][7 - (tbit % 8)];
        end
    end

    // Monitor samples 2 ns after each rising clk edge.
    int          cyc = 0;
    int          cs_cycles, busy_cycles, sck_rises, done_cnt, done_fall, done_cyc, start_cyc;
    logic        sck_prev = 1'b0;
    logic        cs_prev  = 1'b0;
    logic [13:0] wa_q [$];
    logic [7:0]  wd_q [$];

    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (cs)   cs_cycles   = cs_cycles + 1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (sck && !sck_prev) sck_rises = sck_rises + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (cs_prev && !cs) done_fall = done_fall + 1;
        end
        if (wr_en) begin
            wa_q.push_back(wr_address);
            wd_q.push_back(wr_data);
        end
        sck_prev = sck;
        cs_prev  = cs;
    end

    task automatic clear_monitor();
        cs_cycles   = 0;
        busy_cycles = 0;
        sck_rises   = 0;
        done_cnt    = 0;
        done_fall   = 0;
        done_cyc    = -1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic start_xfer(input logic [13:0] a, input logic [13:0] len);
        @(negedge clk);
        start_address = a;
        length        = len;
        start         = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s_timeout: done not seen within %0d cycles", tag, budget);
        else n_pass++;
    endtask

    task automatic check_writes(input string tag, input logic [13:0] ea [], input logic [7:0] ed []);
        n_checks++;
        if (wa_q.size() !== ea.size()) begin
            $display("FAIL %s_wr_count: got %0d required %0d", tag, wa_q.size(), ea.size());
            return;
        end
        n_pass++;
        for (int i = 0; i < ea.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
                $display("FAIL %s_wr%0d: got (%h,%h) required (%h,%h)", tag, i, wa_q[i], wd_q[i], ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        start_address = '0;
        length = '0;
        cipo   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, cs, sck, wr_en} !== 5'b0 || wr_data !== 8'h00 || wr_address !== 14'h0000)
            $display("FAIL reset_outputs: got busy=%b done=%b cs=%b sck=%b wr_en=%b data=%h addr=%h required all 0",
                     busy, done, cs, sck, wr_en, wr_data, wr_address);
        else n_pass++;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        tgt[0] = 8'h01; tgt[1] = 8'h02; tgt[2] = 8'h03; tgt[3] = 8'h04; tgt[4] = 8'h05;
        clear_monitor();
        start_xfer(14'h0000, 14'd5);
        n_checks++;
        if (busy !== 1'b1 || cs !== 1'b1) $display("FAIL basic_busy_cs: got busy=%b cs=%b required 1 1", busy, cs);
        else n_pass++;
        wait_done(2300, "basic");
        repeat (3) @(negedge clk);
        check_writes("basic", '{14'd0, 14'd1, 14'd2, 14'd3, 14'd4}, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        n_checks++;
        if (cs_cycles !== 2050) $display("FAIL basic_cs_cycles: got %0d required 2050", cs_cycles);
        else n_pass++;
        n_checks++;
        if (sck_rises !== 40) $display("FAIL basic_sck_rises: got %0d required 40", sck_rises);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_fall !== 1)
            $display("FAIL basic_done: got pulses=%0d at_cs_fall=%0d required 1 1", done_cnt, done_fall);
        else n_pass++;
    endtask

    task automatic test_msb_first();
        tgt[0] = 8'hA5; tgt[1] = 8'h3C;
        clear_monitor();
        start_xfer(14'h0100, 14'd2);
        wait_done(1100, "msb");
        repeat (2) @(negedge clk);
        check_writes("msb", '{14'h0100, 14'h0101}, '{8'hA5, 8'h3C});
    endtask

    task automatic test_wrap();
        tgt[0] = 8'h11; tgt[1] = 8'h22; tgt[2] = 8'h33;
        clear_monitor();
        start_xfer(14'h3FFE, 14'd3);
        wait_done(1500, "wrap");
        repeat (2) @(negedge clk);
        check_writes("wrap", '{14'h3FFE, 14'h3FFF, 14'h0000}, '{8'h11, 8'h22, 8'h33});
    endtask

    task automatic test_zero_length();
        clear_monitor();
        start_xfer(14'h0123, 14'd0);
        wait_done(5, "zero");
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cyc !== start_cyc + 1) $display("FAIL zero_done_latency: got %0d required %0d", done_cyc - start_cyc, 1);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL zero_done_count: got %0d required 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (cs_cycles !== 0 || busy_cycles !== 0 || sck_rises !== 0)
            $display("FAIL zero_link_idle: got cs=%0d busy=%0d rises=%0d required 0 0 0", cs_cycles, busy_cycles, sck_rises);
        else n_pass++;
        check_writes("zero", '{}, '{});
    endtask

    task automatic test_back_to_back();
        tgt[0] = 8'h11; tgt[1] = 8'h22;
        clear_monitor();
        start_xfer(14'h0040, 14'd2);
        repeat (300) @(negedge clk);
        start_xfer(14'h0200, 14'd5);
        wait_done(1100, "b2b_first");
        // Start held in the DONE cycle (ignored) then retargeted in the next (accepted).
        start_address = 14'h0500;
        length        = 14'd4;
        start         = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_done_start_ignored: got busy=%b done=%b required 0 0", busy, done);
        else n_pass++;
        start_address = 14'h0300;
        length        = 14'd1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL b2b_restart: got busy=%b required 1", busy);
        else n_pass++;
        wait_done(700, "b2b_second");
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt !== 2) $display("FAIL b2b_done_count: got %0d required 2", done_cnt);
        else n_pass++;
        check_writes("b2b", '{14'h0040, 14'h0041, 14'h0300}, '{8'h11, 8'h22, 8'h11});
    endtask

    task automatic test_reset_mid();
        int n = 0;
        tgt[0] = 8'h01; tgt[1] = 8'h02; tgt[2] = 8'h03; tgt[3] = 8'h04; tgt[4] = 8'h05;
        clear_monitor();
        start_xfer(14'h0010, 14'd5);
        while (wa_q.size() < 2 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (wa_q.size() < 2) $display("FAIL rstmid_timeout: writes got %0d required 2", wa_q.size());
        else n_pass++;
        repeat (200) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cs !== 1'b0 || sck !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_at_edge: got cs=%b sck=%b busy=%b required 0 0 0", cs, sck, busy);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        cs_cycles = 0;
        busy_cycles = 0;
        done_cnt = 0;
        repeat (1000) @(negedge clk);
        check_writes("rstmid", '{14'h0010, 14'h0011}, '{8'h01, 8'h02});
        n_checks++;
        if (cs_cycles !== 0 || busy_cycles !== 0 || done_cnt !== 0)
            $display("FAIL rstmid_stays_idle: got cs=%0d busy=%0d done=%0d required 0 0 0", cs_cycles, busy_cycles, done_cnt);
        else n_pass++;
    endtask

    initial begin
        clear_monitor();
        start_cyc = 0;
        test_reset();
        test_basic();
        test_msb_first();
        test_wrap();
        test_zero_length();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
